// File: rtl/audio_i2s_fifo_tx.sv
// audio_i2s_fifo_tx: frame FIFO feeding a free-running I2S serialiser.
// Left word first, MSB one bit clock after each word-select edge.
module audio_i2s_fifo_tx #(
  parameter int BCLK_HALF_DIV = 25,
  parameter int FIFO_DEPTH    = 8,
  parameter int LVL_W         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             enable,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [15:0]      s_left,
  input  logic [15:0]      s_right,
  input  logic             clear_underrun,
  output logic [LVL_W-1:0] fifo_level,
  output logic             underrun,
  output logic [7:0]       underrun_count,
  output logic             audio_bclk,
  output logic             audio_lrclk,
  output logic             audio_dout
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = (BCLK_HALF_DIV > 1) ?
                      $clog2(BCLK_HALF_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX =
    DW'(BCLK_HALF_DIV - 1);
  localparam logic [LVL_W-1:0] LVL_FULL =
    LVL_W'(FIFO_DEPTH);

  logic [31:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [LVL_W-1:0] lvl_q, lvl_d;
  logic [DW-1:0]    div_q, div_d;
  logic             bclk_q, bclk_d;
  logic             lr_q, lr_d;
  logic             dout_q, dout_d;
  logic [4:0]       slot_q, slot_d;
  logic [15:0]      left_q, left_d;
  logic [15:0]      right_q, right_d;
  logic             ur_q, ur_d;
  logic [7:0]       cnt_q, cnt_d, cnt_base;

  logic        empty, push, pop, uev;
  logic        wrap, fall, load;
  logic [31:0] head;

  assign empty   = (lvl_q == '0);
  assign s_ready = (lvl_q != LVL_FULL);
  assign push    = s_valid && s_ready;
  assign wrap    = (div_q == DIV_MAX);
  assign fall    = enable && wrap && bclk_q;
  assign load    = fall && (slot_q == 5'd0);
  assign pop     = load && !empty;
  assign uev     = load && empty;
  assign head    = mem_q[rd_q];

  // Frame load happens on the slot 0->1 fall, so the new
  // left MSB is driven on that very edge.
  always_comb begin
    div_d   = div_q;
    bclk_d  = bclk_q;
    slot_d  = slot_q;
    lr_d    = lr_q;
    dout_d  = dout_q;
    left_d  = left_q;
    right_d = right_q;
    if (!enable) begin
      div_d   = '0;
      bclk_d  = 1'b0;
      slot_d  = '0;
      lr_d    = 1'b0;
      dout_d  = 1'b0;
      left_d  = '0;
      right_d = '0;
    end else begin
      div_d = wrap ? '0 : div_q + 1'b1;
      if (wrap) bclk_d = ~bclk_q;
      if (load) begin
        left_d  = pop ? head[31:16] : 16'h0;
        right_d = pop ? head[15:0]  : 16'h0;
      end
      if (fall) begin
        slot_d = slot_q + 5'd1;
        lr_d   = slot_d[4];
        if (slot_d == 5'd0)
          dout_d = right_d[0];
        else if (slot_d <= 5'd16)
          dout_d = left_d[4'(5'd16 - slot_d)];
        else
          dout_d = right_d[4'(5'd0 - slot_d)];
      end
    end
  end

  // A fresh underrun outranks a coincident clear.
  always_comb begin
    cnt_base = clear_underrun ? 8'h00 : cnt_q;
    ur_d     = uev | (ur_q & ~clear_underrun);
    cnt_d    = cnt_base;
    if (uev && cnt_base != 8'hFF)
      cnt_d = cnt_base + 8'd1;
  end

  always_comb begin
    lvl_d = lvl_q;
    if (push && !pop)
      lvl_d = lvl_q + LVL_W'(1);
    else if (!push && pop)
      lvl_d = lvl_q - LVL_W'(1);
  end

  always_ff @(posedge aclk) begin
    if (push) mem_q[wr_q] <= {s_left, s_right};
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_q    <= '0;
      rd_q    <= '0;
      lvl_q   <= '0;
      div_q   <= '0;
      bclk_q  <= 1'b0;
      slot_q  <= '0;
      lr_q    <= 1'b0;
      dout_q  <= 1'b0;
      left_q  <= '0;
      right_q <= '0;
      ur_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      lvl_q   <= lvl_d;
      div_q   <= div_d;
      bclk_q  <= bclk_d;
      slot_q  <= slot_d;
      lr_q    <= lr_d;
      dout_q  <= dout_d;
      left_q  <= left_d;
      right_q <= right_d;
      ur_q    <= ur_d;
      cnt_q   <= cnt_d;
    end
  end

  assign fifo_level     = lvl_q;
  assign underrun       = ur_q;
  assign underrun_count = cnt_q;
  assign audio_bclk     = bclk_q;
  assign audio_lrclk    = lr_q;
  assign audio_dout     = dout_q;

endmodule

// File: tb/tb_audio_i2s_fifo_tx.sv
// tb_audio_i2s_fifo_tx: directed + random stimulus against a
// frame-level I2S reference model.
module tb_audio_i2s_fifo_tx;

  localparam int H  = 2;
  localparam int D  = 4;
  localparam int LW = 3;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          enable = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [15:0]   s_left = '0;
  logic [15:0]   s_right = '0;
  logic          clear_underrun = 1'b0;
  logic [LW-1:0] fifo_level;
  logic          underrun;
  logic [7:0]    underrun_count;
  logic          audio_bclk, audio_lrclk, audio_dout;

  audio_i2s_fifo_tx #(
    .BCLK_HALF_DIV(H),
    .FIFO_DEPTH(D),
    .LVL_W(LW)
  ) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .enable(enable),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_left(s_left),
    .s_right(s_right),
    .clear_underrun(clear_underrun),
    .fifo_level(fifo_level),
    .underrun(underrun),
    .underrun_count(underrun_count),
    .audio_bclk(audio_bclk),
    .audio_lrclk(audio_lrclk),
    .audio_dout(audio_dout)
  );

  always #5 aclk = ~aclk;

  logic [31:0] q[$];
  int          en_cnt;
  logic [15:0] m_l, m_r;
  logic        m_ur;
  int          m_cnt;
  logic        acc, m_load;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    en_cnt = 0;
    m_l = '0;
    m_r = '0;
    m_ur = 1'b0;
    m_cnt = 0;
    acc = 1'b0;
    m_load = 1'b0;
  endtask

  function automatic int m_slot();
    return (en_cnt / (2 * H)) % 32;
  endfunction

  function automatic logic will_load();
    int n;
    n = en_cnt + 1;
    return enable && (n % (2 * H) == 0) &&
           ((n / (2 * H)) % 32 == 1);
  endfunction

  // One system-clock edge of the frame-level model.
  task automatic model_edge();
    int          sz;
    logic        dp;
    logic [31:0] f;
    acc = 1'b0;
    m_load = 1'b0;
    if (!aresetn) begin
      model_reset();
      return;
    end
    sz = q.size();
    dp = s_valid && (sz < D);
    if (enable) begin
      en_cnt++;
      if (en_cnt % (2 * H) == 0 &&
          (en_cnt / (2 * H)) % 32 == 1)
        m_load = 1'b1;
    end else begin
      en_cnt = 0;
      m_l = '0;
      m_r = '0;
    end
    if (clear_underrun) begin
      m_ur = 1'b0;
      m_cnt = 0;
    end
    if (m_load) begin
      if (sz > 0) begin
        f = q.pop_front();
        m_l = f[31:16];
        m_r = f[15:0];
      end else begin
        m_l = '0;
        m_r = '0;
        m_ur = 1'b1;
        if (m_cnt < 255) m_cnt++;
      end
    end
    if (dp) begin
      q.push_back({s_left, s_right});
      acc = 1'b1;
    end
  endtask

  task automatic check_all();
    int          s;
    logic [31:0] w;
    logic        ed;
    s = m_slot();
    w = {m_l, m_r};
    ed = (s == 0) ? w[0] : w[32 - s];
    chk("bclk", 32'(audio_bclk), 32'((en_cnt / H) % 2));
    chk("lrclk", 32'(audio_lrclk), 32'(s >= 16));
    chk("dout", 32'(audio_dout), 32'(ed));
    chk("level", 32'(fifo_level), 32'(q.size()));
    chk("s_ready", 32'(s_ready), 32'(q.size() != D));
    chk("underrun", 32'(underrun), 32'(m_ur));
    chk("ur_count", 32'(underrun_count), 32'(m_cnt));
  endtask

  task automatic tick();
    @(posedge aclk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic rand_data();
    s_left = 16'($urandom);
    s_right = 16'($urandom);
  endtask

  logic [31:0] frames [6];
  logic [31:0] bits;
  int          idx, nl, n, lvl_save;

  initial begin
    model_reset();
    #2;
    check_all();
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_ready", 32'(s_ready), 32'd1);
    chk("rst_dout", 32'(audio_dout), 32'd0);
    run(2);
    #4 aresetn = 1'b1;

    // Known frame, bit order on bclk rises.
    s_valid = 1'b1;
    s_left = 16'h8001;
    s_right = 16'h00FF;
    enable = 1'b1;
    tick();
    s_valid = 1'b0;
    n = 0;
    while (!m_load && n < 200) begin
      tick();
      n++;
    end
    chk("first_load", 32'(m_load), 32'd1);
    bits = '0;
    for (int k = 0; k < 32; k++) begin
      n = 0;
      do begin
        tick();
        n++;
      end while (en_cnt % (2 * H) != H && n < 100);
      bits = {bits[30:0], audio_dout};
    end
    chk("frame_bits", bits, 32'h800100FF);

    // Underrun accounting, clear coincident with new underrun.
    enable = 1'b0;
    clear_underrun = 1'b1;
    tick();
    clear_underrun = 1'b0;
    enable = 1'b1;
    nl = 0;
    n = 0;
    while (nl < 3 && n < 1000) begin
      tick();
      if (m_load) nl++;
      n++;
    end
    chk("ur_flag3", 32'(underrun), 32'd1);
    chk("ur_cnt3", 32'(underrun_count), 32'd3);
    n = 0;
    while (!will_load() && n < 200) begin
      tick();
      n++;
    end
    clear_underrun = 1'b1;
    tick();
    clear_underrun = 1'b0;
    chk("clr_flag", 32'(underrun), 32'd1);
    chk("clr_cnt", 32'(underrun_count), 32'd1);

    // Preload six frames while parked.
    enable = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) begin
      frames[i] = $urandom;
      frames[i][3:0] = 4'(i);
    end
    idx = 0;
    s_valid = 1'b1;
    {s_left, s_right} = frames[0];
    for (int i = 0; i < 12; i++) begin
      tick();
      if (acc) begin
        idx++;
        {s_left, s_right} = frames[idx];
      end
    end
    chk("pre_ready", 32'(s_ready), 32'd0);
    chk("pre_level", 32'(fifo_level), 32'd4);
    enable = 1'b1;
    n = 0;
    while (idx < 6 && n < 2000) begin
      tick();
      if (acc) begin
        idx++;
        if (idx < 6) {s_left, s_right} = frames[idx];
      end
      n++;
    end
    chk("pre_all_in", 32'(idx), 32'd6);
    s_valid = 1'b0;
    n = 0;
    while (q.size() != 0 && n < 1000) begin
      tick();
      n++;
    end
    run(130);

    // Push and pop on the same edge at level 2.
    n = 0;
    while (m_slot() != 5 && n < 200) begin
      tick();
      n++;
    end
    s_valid = 1'b1;
    rand_data();
    tick();
    rand_data();
    tick();
    s_valid = 1'b0;
    chk("pp_pre", 32'(fifo_level), 32'd2);
    n = 0;
    while (!will_load() && n < 200) begin
      tick();
      n++;
    end
    s_valid = 1'b1;
    rand_data();
    tick();
    s_valid = 1'b0;
    chk("pp_level", 32'(fifo_level), 32'd2);
    run(300);

    // Park at slot 20, then re-enable.
    s_valid = 1'b1;
    rand_data();
    tick();
    s_valid = 1'b0;
    n = 0;
    while (m_slot() != 20 && n < 200) begin
      tick();
      n++;
    end
    lvl_save = q.size();
    enable = 1'b0;
    tick();
    chk("park_bclk", 32'(audio_bclk), 32'd0);
    chk("park_lr", 32'(audio_lrclk), 32'd0);
    chk("park_dout", 32'(audio_dout), 32'd0);
    chk("park_level", 32'(fifo_level), 32'(lvl_save));
    enable = 1'b1;
    for (int i = 0; i < H - 1; i++) begin
      tick();
      chk("reen_low", 32'(audio_bclk), 32'd0);
    end
    tick();
    chk("reen_rise", 32'(audio_bclk), 32'd1);
    run(260);

    // Random traffic, clears and enable toggles.
    for (int i = 0; i < 1500; i++) begin
      s_valid = ($urandom_range(0, 99) < 3);
      rand_data();
      clear_underrun = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 599) == 0) enable = ~enable;
      tick();
    end
    s_valid = 1'b0;
    clear_underrun = 1'b0;
    enable = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 1200) begin
      tick();
      n++;
    end

    // Asynchronous reset mid-frame with three frames queued.
    enable = 1'b0;
    tick();
    n = 0;
    while (q.size() < 4 && n < 20) begin
      s_valid = 1'b1;
      rand_data();
      tick();
      n++;
    end
    s_valid = 1'b0;
    enable = 1'b1;
    run(40);
    chk("mid_level", 32'(fifo_level), 32'd3);
    #2 aresetn = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("arst_level", 32'(fifo_level), 32'd0);
    chk("arst_ready", 32'(s_ready), 32'd1);
    chk("arst_bclk", 32'(audio_bclk), 32'd0);
    run(2);
    #4 aresetn = 1'b1;
    s_valid = 1'b1;
    rand_data();
    tick();
    s_valid = 1'b0;
    run(200);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
